// File: rtl/acc_cmd_pkg.sv
// Shared types and constants for the accumulator command decoder.
// The optional payload timeout is controlled by the ACC_CMD_TIMEOUT_EN macro
// (see acc_cmd_decoder.sv); the package itself does not depend on it.
package acc_cmd_pkg;

    // Opcode carried in bits [2:0] of an opcode byte; codes 6 and 7 are illegal.
    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_CLR  = 3'd1,
        OP_SET  = 3'd2,
        OP_LOAD = 3'd3,
        OP_ADD  = 3'd4,
        OP_INC  = 3'd5
    } opcode_e;

    // Decoder state: waiting for an opcode, or collecting LOAD/ADD payload bytes.
    typedef enum logic {
        IDLE    = 1'b0,
        PAYLOAD = 1'b1
    } state_e;

    // Opcode bits that must be zero for a byte to be a legal opcode.
    localparam logic [7:0] OPC_RSVD_MASK = 8'hF8;

    // True when the byte is one of the six defined opcodes.
    function automatic logic opc_is_legal(input logic [7:0] b);
        return ((b & OPC_RSVD_MASK) == 8'h00) && (b[2:0] <= 3'd5);
    endfunction

endpackage

// File: rtl/acc_cmd_timeout.sv
// Payload idle timer: counts cycles while i_cnt is high, clears on i_clr.
// o_expire fires combinationally on the cycle the count reaches TIMEOUT-1
// with counting still requested, so the caller can abort in that cycle.
module acc_cmd_timeout #(
    parameter int TIMEOUT = 1000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_cnt,
    output logic o_expire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;

    assign o_expire = i_cnt && (cnt_q == CW'(TIMEOUT - 1));

    // Idle counter; clear has priority so an arriving byte always restarts it.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            cnt_q <= '0;
        end else if (i_cnt) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/acc_cmd_decoder.sv
// Byte-stream command decoder feeding the W-bit accumulator.
// Opcode bytes produce one-cycle clr/set/inc/err strobes; LOAD/ADD collect
// NB = ceil(W/8) payload bytes MSB-first, then update o_val and pulse load/add.
// Define ACC_CMD_TIMEOUT_EN to abort a stalled payload after TIMEOUT idle cycles.
module acc_cmd_decoder
    import acc_cmd_pkg::*;
#(
    parameter int W       = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_stb,
    input  logic [7:0]   i_byte,
    output logic         o_clr,
    output logic         o_set,
    output logic         o_load,
    output logic         o_add,
    output logic         o_inc,
    output logic [W-1:0] o_val,
    output logic         o_err,
    output logic         o_busy
);

    localparam int NB  = (W + 7) / 8;
    // Only the earlier NB-1 bytes need storage; the final byte is used live.
    localparam int SRW = (NB > 1) ? (NB - 1) * 8 : 8;
    localparam int BCW = (NB > 1) ? $clog2(NB) : 1;

    state_e           state_q;
    opcode_e          op_q;
    logic [BCW-1:0]   bcnt_q;
    logic [SRW-1:0]   sr_q;
    logic [NB*8-1:0]  word_d;
    logic             expire;
    logic             last_byte;

    // Assembled word if the current byte is shifted in (first byte ends up on top).
    generate
        if (NB == 1) begin : g_word_nb1
            assign word_d = i_byte;
        end else begin : g_word_nbn
            assign word_d = {sr_q, i_byte};
        end
    endgenerate

    assign last_byte = (bcnt_q == BCW'(NB - 1));
    assign o_busy    = (state_q == PAYLOAD);

`ifdef ACC_CMD_TIMEOUT_EN
    logic tmr_cnt;
    logic tmr_clr;

    assign tmr_cnt = (state_q == PAYLOAD) && !i_stb;
    assign tmr_clr = (state_q != PAYLOAD) || i_stb;

    acc_cmd_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clr    (tmr_clr),
        .i_cnt    (tmr_cnt),
        .o_expire (expire)
    );
`else
    assign expire = 1'b0;
`endif

    // Command FSM with registered strobes; strobes default low every cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            op_q    <= OP_NOP;
            bcnt_q  <= '0;
            sr_q    <= '0;
            o_val   <= '0;
            o_clr   <= 1'b0;
            o_set   <= 1'b0;
            o_load  <= 1'b0;
            o_add   <= 1'b0;
            o_inc   <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            o_clr  <= 1'b0;
            o_set  <= 1'b0;
            o_load <= 1'b0;
            o_add  <= 1'b0;
            o_inc  <= 1'b0;
            o_err  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_stb) begin
                        if (!opc_is_legal(i_byte)) begin
                            o_err <= 1'b1;
                        end else begin
                            case (opcode_e'(i_byte[2:0]))
                                OP_CLR: o_clr <= 1'b1;
                                OP_SET: o_set <= 1'b1;
                                OP_INC: o_inc <= 1'b1;
                                OP_LOAD, OP_ADD: begin
                                    op_q    <= opcode_e'(i_byte[2:0]);
                                    bcnt_q  <= '0;
                                    state_q <= PAYLOAD;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                PAYLOAD: begin
                    if (i_stb) begin
                        sr_q <= word_d[SRW-1:0];
                        if (last_byte) begin
                            o_val   <= word_d[W-1:0];
                            o_load  <= (op_q == OP_LOAD);
                            o_add   <= (op_q == OP_ADD);
                            state_q <= IDLE;
                        end else begin
                            bcnt_q <= bcnt_q + 1'b1;
                        end
                    end else if (expire) begin
                        // Stalled payload: drop the partial word and flag it.
                        o_err   <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_cmd_decoder.sv
// Scoreboard bench for acc_cmd_decoder: a W=16 and a W=12 instance share one
// byte stream; a command-level model predicts strobe events and o_val/o_busy.
module tb_acc_cmd_decoder;

    localparam int TMO = 8;
`ifdef ACC_CMD_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    localparam logic [5:0] K_CLR  = 6'b100000;
    localparam logic [5:0] K_SET  = 6'b010000;
    localparam logic [5:0] K_LOAD = 6'b001000;
    localparam logic [5:0] K_ADD  = 6'b000100;
    localparam logic [5:0] K_INC  = 6'b000010;
    localparam logic [5:0] K_ERR  = 6'b000001;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_stb = 1'b0;
    logic [7:0]  i_byte = 8'h00;

    logic        a_clr, a_set, a_load, a_add, a_inc, a_err, a_busy;
    logic [15:0] a_val;
    logic        b_clr, b_set, b_load, b_add, b_inc, b_err, b_busy;
    logic [11:0] b_val;

    always #5 i_clk = ~i_clk;

    acc_cmd_decoder #(.W(16), .TIMEOUT(TMO)) u_dut16 (
        .i_clk(i_clk), .i_reset(i_reset), .i_stb(i_stb), .i_byte(i_byte),
        .o_clr(a_clr), .o_set(a_set), .o_load(a_load), .o_add(a_add),
        .o_inc(a_inc), .o_val(a_val), .o_err(a_err), .o_busy(a_busy)
    );

    acc_cmd_decoder #(.W(12), .TIMEOUT(TMO)) u_dut12 (
        .i_clk(i_clk), .i_reset(i_reset), .i_stb(i_stb), .i_byte(i_byte),
        .o_clr(b_clr), .o_set(b_set), .o_load(b_load), .o_add(b_add),
        .o_inc(b_inc), .o_val(b_val), .o_err(b_err), .o_busy(b_busy)
    );

    typedef struct {
        logic [5:0]  kind;
        logic [15:0] val;
        int          edge_n;
    } ev_t;

    ev_t qa[$];
    ev_t qb[$];

    int n_chk = 0;
    int n_err = 0;
    int edge_n = 0;

    // Command-level reference state.
    bit          m_pay = 1'b0;
    int          m_got = 0;
    int          m_idle = 0;
    bit          m_is_load = 1'b0;
    logic [15:0] m_acc = 16'h0;
    logic [15:0] m_val = 16'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic void push(input logic [5:0] k, input logic [15:0] v);
        ev_t e;
        e.kind = k;
        e.val = v;
        e.edge_n = edge_n;
        qa.push_back(e);
        qb.push_back(e);
    endfunction

    // Reference model: one step per clock edge, in terms of commands and bytes.
    always @(posedge i_clk) begin
        edge_n++;
        if (i_reset) begin
            m_pay = 1'b0;
            m_val = 16'h0;
        end else if (m_pay) begin
            if (i_stb) begin
                m_acc = {m_acc[7:0], i_byte};
                m_got++;
                m_idle = 0;
                if (m_got == 2) begin
                    m_val = m_acc;
                    m_pay = 1'b0;
                    push(m_is_load ? K_LOAD : K_ADD, m_acc);
                end
            end else begin
                m_idle++;
                if (TO_EN && m_idle == TMO) begin
                    m_pay = 1'b0;
                    push(K_ERR, 16'h0);
                end
            end
        end else if (i_stb) begin
            if (i_byte > 8'd5) push(K_ERR, 16'h0);
            else if (i_byte == 8'd1) push(K_CLR, 16'h0);
            else if (i_byte == 8'd2) push(K_SET, 16'h0);
            else if (i_byte == 8'd5) push(K_INC, 16'h0);
            else if (i_byte == 8'd3 || i_byte == 8'd4) begin
                m_pay = 1'b1;
                m_is_load = (i_byte == 8'd3);
                m_got = 0;
                m_idle = 0;
                m_acc = 16'h0;
            end
        end
    end

    task automatic mon(input int d, input logic [5:0] s, input logic [15:0] v, input logic busy);
        ev_t e;
        logic [15:0] msk;
        string tag;
        bit have;
        msk = (d == 0) ? 16'hFFFF : 16'h0FFF;
        tag = (d == 0) ? "w16" : "w12";
        chk({tag, ".busy"}, 32'(busy), 32'(m_pay));
        chk({tag, ".val_hold"}, 32'(v), 32'(m_val & msk));
        chk({tag, ".onehot"}, 32'($countones(s) <= 1), 32'd1);
        have = (d == 0) ? (qa.size() != 0) : (qb.size() != 0);
        if (have) e = (d == 0) ? qa[0] : qb[0];
        if (s != 6'b0) begin
            if (!have) begin
                chk({tag, ".unexpected_strobe"}, 32'(s), 32'd0);
            end else begin
                if (d == 0) void'(qa.pop_front()); else void'(qb.pop_front());
                chk({tag, ".kind"}, 32'(s), 32'(e.kind));
                chk({tag, ".latency"}, 32'(edge_n), 32'(e.edge_n));
                if (e.kind == K_LOAD || e.kind == K_ADD)
                    chk({tag, ".operand"}, 32'(v), 32'(e.val & msk));
            end
        end else if (have && e.edge_n <= edge_n) begin
            if (d == 0) void'(qa.pop_front()); else void'(qb.pop_front());
            chk({tag, ".missing_strobe"}, 32'd0, 32'(e.kind));
        end
    endtask

    // Monitor samples on the falling edge, away from the active edge.
    always @(negedge i_clk) begin
        mon(0, {a_clr, a_set, a_load, a_add, a_inc, a_err}, a_val, a_busy);
        mon(1, {b_clr, b_set, b_load, b_add, b_inc, b_err}, {4'h0, b_val}, b_busy);
    end

    task automatic send(input logic [7:0] b);
        i_stb = 1'b1;
        i_byte = b;
        @(posedge i_clk);
        #1;
        i_stb = 1'b0;
    endtask

    task automatic idle(input int n);
        i_stb = 1'b0;
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic pulse_reset();
        i_stb = 1'b0;
        i_reset = 1'b1;
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
    endtask

    initial begin
        i_reset = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        chk("reset.strobes16", 32'({a_clr, a_set, a_load, a_add, a_inc, a_err, a_busy}), 32'd0);
        chk("reset.val16", 32'(a_val), 32'd0);
        chk("reset.strobes12", 32'({b_clr, b_set, b_load, b_add, b_inc, b_err, b_busy}), 32'd0);
        i_reset = 1'b0;

        // LOAD 0x1234, then ADD 0xFFFF immediately followed by INC.
        send(8'h03); send(8'h12); send(8'h34);
        send(8'h04); send(8'hFF); send(8'hFF); send(8'h05);
        idle(2);
        // Illegal opcodes then CLR; SET/NOP.
        send(8'h06); idle(1); send(8'h09); idle(1); send(8'h01); send(8'h00); send(8'h02);
        idle(1);
        // Wide first byte: W=12 keeps 0xABC.
        send(8'h03); send(8'hFA); send(8'hBC);
        idle(1);
        // Reset in the middle of a payload, then SET.
        send(8'h04); send(8'h55);
        pulse_reset();
        send(8'h02);
        idle(2);
        // Payload stall: abort with timeout, byte on the limit cycle, long stall.
        send(8'h03); send(8'h11); idle(TMO + 4);
        send(8'h03); send(8'h11); idle(TMO - 1); send(8'h22);
        idle(2);
        send(8'h03); send(8'h11); idle(100); send(8'h22);
        idle(3);

        // Random byte stream with gaps and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2) pulse_reset();
            else if (r < 15) idle($urandom_range(1, (r < 5) ? TMO + 2 : 2));
            else if ($urandom_range(0, 3) == 0) send(8'($urandom));
            else send(8'($urandom_range(0, 7)));
        end

        idle(TMO + 4);
        chk("drain.w16", 32'(qa.size()), 32'd0);
        chk("drain.w12", 32'(qb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
